// File: rtl/byte_serial_adder.sv
// Byte-serial adder: one 8-bit full adder reused once per byte lane, NBYTES cycles per operation.
// Optional subtract mode when BYTE_SERIAL_ADDER_SUB_EN is defined (adds port sub).
module byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   num1,
    input  logic [8*NBYTES-1:0]   num2,
    input  logic                  cin,
`ifdef BYTE_SERIAL_ADDER_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state, nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q, b_q;
    logic          cin_q, carry;
    logic          accept;

    logic [7:0]    fa_a, fa_b, fa_s;
    logic          fa_ci, fa_co, c7;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt    = state;
        busy   = 1'b0;
        done   = 1'b0;
        accept = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) nxt = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (idx == LAST) nxt = DONE;
            end
            DONE: begin
                done   = 1'b1;
                accept = start;
                nxt    = start ? ADD : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Shared byte adder; carry into bit 7 recovered from the sum bit for overflow.
    always_comb begin
        fa_a          = a_q[{idx, 3'b000} +: 8];
        fa_b          = b_q[{idx, 3'b000} +: 8];
        fa_ci         = (idx == '0) ? cin_q : carry;
        {fa_co, fa_s} = {1'b0, fa_a} + {1'b0, fa_b} + {8'd0, fa_ci};
        c7            = fa_a[7] ^ fa_b[7] ^ fa_s[7];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q <= num1;
            idx <= '0;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
            // Subtract as num1 + ~num2 + 1; cout=1 then means no borrow.
            b_q   <= sub ? ~num2 : num2;
            cin_q <= sub | cin;
`else
            b_q   <= num2;
            cin_q <= cin;
`endif
        end else if (state == ADD) begin
            sum[{idx, 3'b000} +: 8] <= fa_s;
            carry                   <= fa_co;
            idx                     <= (idx == LAST) ? '0 : idx + IW'(1);
            if (idx == LAST) begin
                cout <= fa_co;
                ovf  <= c7 ^ fa_co;
            end
        end
    end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder (NBYTES=4); exercises subtract mode when
// BYTE_SERIAL_ADDER_SUB_EN is defined.
module tb_byte_serial_adder;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         reset, start, cin, sub;
    logic [W-1:0] num1, num2;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_bad = 0;

    byte_serial_adder #(.NBYTES(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .num1  (num1),
        .num2  (num2),
        .cin   (cin),
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic, returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ci, v;
        bb   = s ? ~b : b;
        ci   = s ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        v    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {v, full};
    endfunction

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input logic [W-1:0] esum,
                         input logic ecout, input logic eovf);
        int ndone;
        num1  = a;
        num2  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        tick;
        start = 1'b0;
        num1  = $urandom;
        num2  = $urandom;
        cin   = ~c;
        sub   = ~s;
        check({tag, "/busy_E"}, W'(busy), W'(1));
        check({tag, "/done_E"}, W'(done), W'(0));
        ndone = 0;
        for (int k = 1; k < NB; k++) begin
            tick;
            check({tag, "/busy_run"}, W'(busy), W'(1));
            if (done) ndone++;
        end
        check({tag, "/early_done"}, W'(ndone), W'(0));
        tick;
        check({tag, "/busy_end"}, W'(busy), W'(0));
        check({tag, "/done"}, W'(done), W'(1));
        check({tag, "/sum"}, sum, esum);
        check({tag, "/cout"}, W'(cout), W'(ecout));
        check({tag, "/ovf"}, W'(ovf), W'(eovf));
        tick;
        check({tag, "/done_drop"}, W'(done), W'(0));
        check({tag, "/sum_hold"}, sum, esum);
    endtask

    logic [W-1:0] ra, rb, a2, b2;
    logic         rc, rs;
    logic [W+1:0] r;
    int           ndone;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num1  = '0;
        num2  = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        tick;
        tick;
        check("rst/busy", W'(busy), W'(0));
        check("rst/done", W'(done), W'(0));
        check("rst/sum",  sum, '0);
        check("rst/cout", W'(cout), W'(0));
        check("rst/ovf",  W'(ovf), W'(0));
        reset = 1'b0;
        tick;

        do_op("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 1'b0;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`endif
            if (i % 4 == 1) ra[W-1] = rb[W-1];
            r = model(ra, rb, rc, rs);
            do_op("rand", ra, rb, rc, rs, r[W-1:0], r[W], r[W+1]);
        end

        // start held high: operands change mid-run, next op accepted in the done cycle.
        ra = $urandom;
        rb = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        num1  = ra;
        num2  = rb;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        tick;
        check("hold/busy_E", W'(busy), W'(1));
        ndone = 0;
        tick;
        if (done) ndone++;
        tick;
        if (done) ndone++;
        num1 = a2;
        num2 = b2;
        cin  = 1'b1;
        tick;
        if (done) ndone++;
        check("hold/no_early_done", W'(ndone), W'(0));
        tick;
        r = model(ra, rb, 1'b0, 1'b0);
        check("hold/done", W'(done), W'(1));
        check("hold/sum1", sum, r[W-1:0]);
        check("hold/cout1", W'(cout), W'(r[W]));
        tick;
        check("b2b/busy", W'(busy), W'(1));
        check("b2b/done", W'(done), W'(0));
        start = 1'b0;
        for (int k = 1; k < NB; k++) tick;
        tick;
        r = model(a2, b2, 1'b1, 1'b0);
        check("b2b/done2", W'(done), W'(1));
        check("b2b/sum2", sum, r[W-1:0]);
        check("b2b/ovf2", W'(ovf), W'(r[W+1]));
        tick;

        // Reset in the middle of a run.
        num1  = 32'hA5A5_A5A5;
        num2  = 32'h0101_0101;
        cin   = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        check("abort/busy", W'(busy), W'(0));
        check("abort/done", W'(done), W'(0));
        check("abort/sum",  sum, '0);
        check("abort/cout", W'(cout), W'(0));
        check("abort/ovf",  W'(ovf), W'(0));
        tick;
        tick;
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (done) ndone++;
        end
        check("abort/no_done", W'(ndone), W'(0));
        do_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

`ifdef BYTE_SERIAL_ADDER_SUB_EN
        do_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
